bram_snapshot_writer: RTL and testbench
=======================================

Name: bram_snapshot_writer

Overview:
- Capture stage directly upstream of the dual-port AXI-lite BRAM; drives its FPGA-side write port (bram_addr, bram_din, bram_we).
- Takes a valid-qualified sample stream (e.g. correlator output), waits for arm plus an optional trigger, and writes a programmable number of decimated samples to consecutive addresses from 0.
- Reports busy/done so software polls done, then reads the buffer over AXI-lite.

Parameters:
- DATA_WIDTH, 32, sample and BRAM word width.
- ADDR_WIDTH, 10, BRAM address width; buffer depth is 2**ADDR_WIDTH words.

Ports:
- fpga_clk  in  1  single clock; all logic sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_WIDTH  input sample.
- din_valid  in  1  din qualifier; no backpressure.
- arm  in  1  single-cycle start request.
- abort  in  1  cancels an in-progress capture.
- trig_en  in  1  1 = wait for trigger, 0 = free-run start.
- trigger  in  1  start condition, qualified by din_valid.
- capture_len  in  ADDR_WIDTH+1  number of words to store.
- decim  in  8  keep 1 of every decim+1 valid samples.
- bram_addr  out  ADDR_WIDTH  write address to BRAM port A.
- bram_din  out  DATA_WIDTH  write data to BRAM port A.
- bram_we  out  1  write enable to BRAM port A.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- words_written  out  ADDR_WIDTH+1  words stored by the current or last capture.

Behaviour:
- Reset: state IDLE; bram_addr=0, bram_din=0, bram_we=0, busy=0, done=0, words_written=0, decimation counter=0.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE or DONE, arm=1 -> ARMED.
  - Latch capture_len, trig_en and decim.
  - Clear done, words_written and the write pointer.
  - capture_len=0 or capture_len > 2**ADDR_WIDTH is latched as 2**ADDR_WIDTH.
- arm while in ARMED or CAPTURE: ignored.
- ARMED: start = din_valid && (!trig_en || trigger).
  - On start, that sample is the first kept sample; it writes address 0 and the state becomes CAPTURE.
  - If latched length is 1, the state goes straight to DONE.
- Decimation:
  - The counter resets to 0 on start.
  - Each din_valid in CAPTURE increments it; a sample is kept when the counter reaches decim, and the counter then wraps to 0.
  - decim=0 keeps every valid sample.
  - The start sample is always kept.
- Write path is registered, latency 1.
  - On a kept sample at cycle t: bram_we=1, bram_din=din, bram_addr=pointer at cycle t+1.
  - The pointer then increments and words_written increments at t+1.
  - bram_we=0 on every other cycle.
- CAPTURE -> DONE in the same cycle the last kept sample is registered (words_written reaches the latched length).
  - The pointer does not wrap past 2**ADDR_WIDTH-1.
  - No further writes occur after DONE.
- DONE: done held at 1 and words_written frozen until the next arm.
- abort=1 in ARMED or CAPTURE -> IDLE next cycle.
  - A write registered in the abort cycle still completes.
  - done stays 0; words_written keeps its count.
- abort and arm in the same cycle: abort wins; the state ends in IDLE.
- trigger while in CAPTURE: ignored (no retrigger).
- trig_en=1 with trigger high but din_valid low: no start.
- rst mid-capture: immediately returns to the reset values; partial BRAM contents are left untouched.
- Trigger and the decimation logic are single-cycle; no combinational path from din to the bram outputs.

Decomposition:
- Shared package holds:
  - the state encoding localparams (IDLE=0, ARMED=1, CAPTURE=2, DONE=3);
  - the depth constant 2**ADDR_WIDTH;
  - the clamp function for capture_len.
- One sub-module is natural: snapshot_decimator (counter plus keep strobe, with a synchronous clear on start). The FSM and write register stay in the top level.
- Integration: instantiated beside the BRAM wrapper on fpga_clk, with bram_dout unused.

Test Plan:
- Free-run: trig_en=0, decim=0, capture_len=8, din=0..15 continuous valid, pulse arm -> writes 0..7 to addresses 0..7, bram_we high 8 consecutive cycles, done=1, words_written=8.
- Triggered: trig_en=1, capture_len=4, trigger coincident with din=0x55 valid -> address 0 gets 0x55, addresses 1..3 get the next three samples; no writes before the trigger; busy=1 while waiting.
- Decimation with gaps: decim=2, capture_len=3, valid asserted every other cycle with din=1..9 -> addresses 0..2 get 1,4,7; done after the 7th sample.
- Full depth: ADDR_WIDTH=4, capture_len=0 -> 16 writes to addresses 0..15, words_written=16, no write to address 0 after the final one; re-arm clears done and restarts at 0.
- Abort: abort after 5 of 10 writes -> state IDLE, done=0, words_written=5, no further bram_we; an arm in the same cycle as abort has no effect.
- Reset mid-capture: rst during CAPTURE -> all outputs return to their reset values next cycle; a subsequent arm performs a normal capture from address 0.

Source files
------------

// File: rtl/bram_snapshot_writer_pkg.sv
// Shared types and helpers for the BRAM snapshot writer: state encoding,
// default sizing and the capture-length clamp.
package bram_snapshot_writer_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Zero or oversize requests mean "fill the whole buffer".
  function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] depth);
    if (len == 32'd0 || len > depth) return depth;
    return len;
  endfunction

endpackage

// File: rtl/bram_snapshot_writer_if.sv
// FPGA-side write port of the capture BRAM (port A).
interface bram_snapshot_writer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic                  bram_we;

  modport master (output bram_addr, output bram_din, output bram_we);
  modport slave  (input  bram_addr, input  bram_din, input  bram_we);
endinterface

// File: rtl/bram_snapshot_writer_decimator.sv
// Keep-1-of-(decim+1) strobe over valid samples; cleared by the capture start.
module snapshot_decimator #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] decim,
  output logic                 keep_c
);

  logic [CNT_WIDTH-1:0] cnt_q;

  // Compare before incrementing so decim valid samples are skipped between keeps.
  assign keep_c = en && (cnt_q == decim);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == decim) ? '0 : CNT_WIDTH'(cnt_q + 1'b1);
    end
  end

endmodule

// File: rtl/bram_snapshot_writer.sv
// Arm/trigger-controlled snapshot capture into BRAM port A, with decimation,
// abort and busy/done status for software polling.
module bram_snapshot_writer
  import bram_snapshot_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  fpga_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig_en,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH:0]   capture_len,
  input  logic [7:0]            decim,
  bram_snapshot_writer_if.master bram,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  trig_en_q, trig_en_d;
  logic [7:0]            decim_q, decim_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]      ww_q, ww_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  we_q, we_d;

  logic start_c;
  logic cap_valid_c;
  logic dec_keep_c;
  logic keep_c;

  assign start_c     = (state_q == ST_ARMED) && din_valid && (!trig_en_q || trigger);
  assign cap_valid_c = (state_q == ST_CAPTURE) && din_valid;
  assign keep_c      = start_c || dec_keep_c;

  snapshot_decimator #(.CNT_WIDTH(8)) u_decim (
    .clk    (fpga_clk),
    .rst    (rst),
    .clear  (start_c),
    .en     (cap_valid_c),
    .decim  (decim_q),
    .keep_c (dec_keep_c)
  );

  // Next-state, write-register and status logic.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    trig_en_d = trig_en_q;
    decim_d   = decim_q;
    ptr_d     = ptr_q;
    ww_d      = ww_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    we_d      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d   = ST_ARMED;
          len_d     = LEN_W'(clamp_len(32'(capture_len), 32'(DEPTH)));
          trig_en_d = trig_en;
          decim_d   = decim;
          ptr_d     = '0;
          ww_d      = '0;
        end
      end
      ST_ARMED: begin
        if (start_c) state_d = ST_CAPTURE;
      end
      default: ;
    endcase

    // The last kept word ends the capture without advancing past the buffer end.
    if (keep_c) begin
      we_d   = 1'b1;
      addr_d = ptr_q;
      dout_d = din;
      ww_d   = LEN_W'(ww_q + 1'b1);
      if (ww_d == len_q) state_d = ST_DONE;
      else               ptr_d   = ADDR_WIDTH'(ptr_q + 1'b1);
    end

    if (abort && (state_q == ST_ARMED || state_q == ST_CAPTURE)) state_d = ST_IDLE;

    busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      trig_en_q <= 1'b0;
      decim_q   <= '0;
      ptr_q     <= '0;
      ww_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      trig_en_q <= trig_en_d;
      decim_q   <= decim_d;
      ptr_q     <= ptr_d;
      ww_q      <= ww_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      we_q      <= we_d;
    end
  end

  assign bram.bram_addr = addr_q;
  assign bram.bram_din  = dout_q;
  assign bram.bram_we   = we_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign words_written  = ww_q;

endmodule

// File: tb/tb_bram_snapshot_writer.sv
// Directed bench for bram_snapshot_writer at a 16-word depth; writes seen on
// the BRAM port are logged and compared against hand-computed expectations.
module tb_bram_snapshot_writer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          arm;
  logic          abort;
  logic          trig_en;
  logic          trigger;
  logic [AW:0]   capture_len;
  logic [7:0]    decim;
  logic          busy;
  logic          done;
  logic [AW:0]   words_written;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  int base;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];

  bram_snapshot_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

  bram_snapshot_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .fpga_clk      (clk),
    .rst           (rst),
    .din           (din),
    .din_valid     (din_valid),
    .arm           (arm),
    .abort         (abort),
    .trig_en       (trig_en),
    .trigger       (trigger),
    .capture_len   (capture_len),
    .decim         (decim),
    .bram          (bif),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Each write pulse lasts one cycle, so one negedge sample per write.
  always @(negedge clk) begin
    if (bif.bram_we === 1'b1) begin
      log_addr.push_back(32'(bif.bram_addr));
      log_data.push_back(bif.bram_din);
      log_cyc.push_back(cyc_n);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_arm(input logic [AW:0] len, input logic [7:0] dec, input logic ten);
    capture_len = len;
    decim       = dec;
    trig_en     = ten;
    arm         = 1'b1;
    cyc();
    arm         = 1'b0;
  endtask

  task automatic stream(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      din       = start + 32'(i);
      din_valid = 1'b1;
      cyc();
    end
    din_valid = 1'b0;
  endtask

  task automatic check_log(input string tag, input int b, input int n, input logic [31:0] data0, input int step);
    check({tag, "_count"}, 32'(log_addr.size() - b), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (b + i < log_addr.size()) begin
        check({tag, "_addr"}, log_addr[b+i], 32'(i));
        check({tag, "_data"}, log_data[b+i], data0 + 32'(i * step));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(bif.bram_addr), 32'd0);
    check({tag, "_din"},  bif.bram_din, 32'd0);
    check({tag, "_we"},   32'(bif.bram_we), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ww"},   32'(words_written), 32'd0);
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; arm = 1'b0; abort = 1'b0;
    trig_en = 1'b0; trigger = 1'b0; capture_len = '0; decim = '0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    check_reset_outputs("reset");

    // Free-run, every sample kept.
    pulse_arm(5'd8, 8'd0, 1'b0);
    check("free_busy_armed", 32'(busy), 32'd1);
    base = log_addr.size();
    stream(32'd0, 16);
    cyc(); cyc();
    check_log("free", base, 8, 32'd0, 1);
    if (log_cyc.size() >= base + 8)
      check("free_contiguous", 32'(log_cyc[base+7] - log_cyc[base]), 32'd7);
    check("free_done", 32'(done), 32'd1);
    check("free_busy", 32'(busy), 32'd0);
    check("free_ww", 32'(words_written), 32'd8);

    // Triggered start; trigger without valid must not start, retrigger ignored.
    pulse_arm(5'd4, 8'd0, 1'b1);
    base = log_addr.size();
    stream(32'h10, 3);
    din = 32'h99; trigger = 1'b1; din_valid = 1'b0;
    cyc();
    check("trig_busy_wait", 32'(busy), 32'd1);
    check("trig_no_early_write", 32'(log_addr.size() - base), 32'd0);
    stream(32'h55, 6);
    trigger = 1'b0;
    cyc(); cyc();
    check_log("trig", base, 4, 32'h55, 1);
    check("trig_done", 32'(done), 32'd1);
    check("trig_ww", 32'(words_written), 32'd4);

    // Decimation by 3 with gapped valids.
    pulse_arm(5'd3, 8'd2, 1'b0);
    base = log_addr.size();
    for (int i = 1; i <= 9; i++) begin
      din = 32'(i); din_valid = 1'b1;
      cyc();
      din_valid = 1'b0;
      if (i == 6) check("decim_done_before7", 32'(done), 32'd0);
      if (i == 7) check("decim_done_at7", 32'(done), 32'd1);
      cyc();
    end
    check_log("decim", base, 3, 32'd1, 3);
    check("decim_ww", 32'(words_written), 32'd3);

    // Full depth via capture_len=0, then re-arm restarts at address 0.
    pulse_arm(5'd0, 8'd0, 1'b0);
    base = log_addr.size();
    stream(32'h100, 20);
    cyc(); cyc();
    check_log("full", base, 16, 32'h100, 1);
    check("full_ww", 32'(words_written), 32'd16);
    check("full_done", 32'(done), 32'd1);
    check("full_last_addr", 32'(bif.bram_addr), 32'd15);
    pulse_arm(5'd2, 8'd0, 1'b0);
    check("rearm_done_clr", 32'(done), 32'd0);
    check("rearm_ww_clr", 32'(words_written), 32'd0);
    check("rearm_busy", 32'(busy), 32'd1);
    base = log_addr.size();
    stream(32'h200, 4);
    cyc(); cyc();
    check_log("rearm", base, 2, 32'h200, 1);
    check("rearm_ww", 32'(words_written), 32'd2);

    // Abort after 5 of 10, with a simultaneous arm that must be ignored.
    pulse_arm(5'd10, 8'd0, 1'b0);
    base = log_addr.size();
    stream(32'h300, 5);
    abort = 1'b1; arm = 1'b1; capture_len = 5'd3;
    cyc();
    abort = 1'b0; arm = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ww", 32'(words_written), 32'd5);
    check("abort_we", 32'(bif.bram_we), 32'd0);
    stream(32'h380, 6);
    cyc(); cyc();
    check_log("abort", base, 5, 32'h300, 1);
    check("abort_still_idle", 32'(busy), 32'd0);

    // Reset in the middle of a capture.
    pulse_arm(5'd8, 8'd0, 1'b0);
    base = log_addr.size();
    stream(32'h400, 3);
    check("midrst_busy_pre", 32'(busy), 32'd1);
    din = 32'h4ff; din_valid = 1'b1; rst = 1'b1;
    cyc();
    rst = 1'b0; din_valid = 1'b0;
    check_reset_outputs("midrst");
    check_log("midrst_partial", base, 3, 32'h400, 1);
    pulse_arm(5'd2, 8'd0, 1'b0);
    base = log_addr.size();
    stream(32'h500, 4);
    cyc(); cyc();
    check_log("post_rst", base, 2, 32'h500, 1);
    check("post_rst_done", 32'(done), 32'd1);
    check("post_rst_ww", 32'(words_written), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
